adc_serial_tx: RTL and testbench

//   Chip-side serial ADC transmitter: the counterpart of the ADC_control receiver. On a DAC_STP_EXT

---
 rtl/adc_serial_tx_if.sv | 25 ++
 rtl/adc_serial_tx.sv | 148 ++++++++++++++
 tb/tb_adc_serial_tx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_tx_if.sv
// Signal bundle between the host/sample source (master) and adc_serial_tx (slave).
interface adc_serial_tx_if #(parameter int DATA_W = 16);
    logic              slp;
    logic              rst_adc;
    logic              dac_stp_ext;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              clk_s_d_out;
    logic              adc_out;
    logic              busy;
    logic              frame_done;
    logic              underrun;
    logic              overrun;

    modport master (
        output slp, rst_adc, dac_stp_ext, sample_data, sample_valid,
        input  sample_ready, clk_s_d_out, adc_out, busy, frame_done, underrun, overrun
    );

    modport slave (
        input  slp, rst_adc, dac_stp_ext, sample_data, sample_valid,
        output sample_ready, clk_s_d_out, adc_out, busy, frame_done, underrun, overrun
    );
endinterface

// File: rtl/adc_serial_tx.sv
// Serial ADC transmitter: on a DAC_STP_EXT rising edge, shifts one sample out MSB first with CLK_S_D_OUT.
// Optional ADC_TX_PATTERN_EN replaces sample_data with an internal per-frame ramp.
module adc_serial_tx #(
    parameter int DATA_W   = 16,
    parameter int HALF_DIV = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic            clk,
    input  logic            rst,
    adc_serial_tx_if.slave  bus
);
    localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [HW-1:0]     half_q, half_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              sclk_q, sclk_d;
    logic              done_q, done_d;
    logic              under_q, under_d;
    logic              over_q, over_d;
    logic              stp_q;
    logic              abort, start;
    logic [DATA_W-1:0] cap_data;
    logic              cap_valid;

    assign abort = bus.slp | bus.rst_adc;
    assign start = bus.dac_stp_ext & ~stp_q;

`ifdef ADC_TX_PATTERN_EN
    logic [DATA_W-1:0] ramp_q, ramp_d;
    logic              unused_sample;
    assign unused_sample    = ^{bus.sample_data, bus.sample_valid};
    assign cap_data         = ramp_q;
    assign cap_valid        = 1'b1;
    assign bus.sample_ready = 1'b0;

    always_comb begin
        ramp_d = ramp_q;
        if (!abort && state_q == IDLE && start) ramp_d = ramp_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ramp_q <= '0;
        else     ramp_q <= ramp_d;
    end
`else
    assign cap_data         = bus.sample_data;
    assign cap_valid        = bus.sample_valid;
    assign bus.sample_ready = (state_q == IDLE) & start & ~abort;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        half_d  = half_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;
        under_d = under_q;
        over_d  = over_q;
        if (abort) begin
            state_d = IDLE;
            shreg_d = '0;
            half_d  = '0;
            bit_d   = '0;
            gap_d   = '0;
            sclk_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_d = cap_valid ? cap_data : '0;
                        under_d = under_q | ~cap_valid;
                        half_d  = '0;
                        bit_d   = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (start) over_d = 1'b1;
                    if (half_q == HW'(HALF_DIV - 1)) begin
                        half_d = '0;
                        sclk_d = ~sclk_q;
                        // rising edges are counted; the falling edge after the last one ends the frame
                        if (!sclk_q)                   bit_d   = bit_q + 1'b1;
                        else if (bit_q == BW'(DATA_W)) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end else                       shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end
                GAP: begin
                    if (start) over_d = 1'b1;
                    if (gap_q == GW'(GAP_CYC - 1)) begin
                        gap_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            half_q  <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
            stp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
            under_q <= under_d;
            over_q  <= over_d;
            stp_q   <= bus.dac_stp_ext;
        end
    end

    assign bus.clk_s_d_out = sclk_q;
    assign bus.adc_out     = (state_q == SHIFT) & shreg_q[DATA_W-1];
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_done  = done_q;
    assign bus.underrun    = under_q;
    assign bus.overrun     = over_q;
endmodule

// File: tb/tb_adc_serial_tx.sv
// Bench for adc_serial_tx: a receiver-side monitor decodes frames on CLK_S_D_OUT rises and is
// compared with the frame word, timing and sticky flags predicted from the transmitter's rules.
module tb_adc_serial_tx;
    localparam int DW        = 16;
    localparam int HD        = 4;
    localparam int GC        = 2;
    localparam int FRAME_LAT = 1 + 2 * HD * DW + GC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_serial_tx_if #(.DATA_W(DW)) bus ();
    adc_serial_tx #(.DATA_W(DW), .HALF_DIV(HD), .GAP_CYC(GC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Receiver model: shift in adc_out on each CLK_S_D_OUT rise, close the frame on frame_done.
    int            done_cyc_q[$];
    logic [DW-1:0] word_q[$];
    int            bits_q[$];
    logic [DW-1:0] rx_word    = '0;
    int            rx_bits    = 0;
    int            first_rise = 0;
    int            stab_err   = 0;
    logic          prev_sclk  = 1'b0;
    logic          prev_adc   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            rx_word = '0; rx_bits = 0; prev_sclk = 1'b0; prev_adc = 1'b0;
        end else begin
            if (bus.clk_s_d_out && !prev_sclk) begin
                rx_word = {rx_word[DW-2:0], bus.adc_out};
                rx_bits++;
                if (rx_bits == 1) first_rise = cyc;
            end
            if (bus.clk_s_d_out && (bus.adc_out !== prev_adc)) stab_err++;
            if (!bus.busy && (bus.adc_out || bus.clk_s_d_out)) stab_err++;
            if (bus.frame_done) begin
                done_cyc_q.push_back(cyc);
                word_q.push_back(rx_word);
                bits_q.push_back(rx_bits);
            end
            if (!bus.busy) begin rx_word = '0; rx_bits = 0; end
            prev_sclk = bus.clk_s_d_out;
            prev_adc  = bus.adc_out;
        end
    end

    logic          m_under = 1'b0;
    logic          m_over  = 1'b0;
    logic [DW-1:0] m_ramp  = '0;

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 500) begin @(negedge clk); t++; end
        if (bus.busy) check("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic wait_bits(input int n);
        int t = 0;
        while (rx_bits < n && t < 300) begin @(negedge clk); t++; end
        if (rx_bits < n) check("rise_timeout", rx_bits, n);
    endtask

    task automatic run_frame(input logic [DW-1:0] data, input logic valid,
                             input logic [DW-1:0] exp_word, input bit mid_start);
        int n0, sc, t;
        wait_idle();
        @(posedge clk); #1;
        bus.sample_data  = data;
        bus.sample_valid = valid;
        bus.dac_stp_ext  = 1'b1;
        sc = cyc;
        n0 = done_cyc_q.size();
        @(negedge clk);
`ifdef ADC_TX_PATTERN_EN
        check("sample_ready", {31'd0, bus.sample_ready}, 32'd0);
`else
        check("sample_ready", {31'd0, bus.sample_ready}, 32'd1);
        m_under = m_under | ~valid;
`endif
        @(posedge clk); #1;
        bus.dac_stp_ext  = 1'b0;
        bus.sample_valid = 1'($urandom);
        bus.sample_data  = DW'($urandom);
        if (mid_start) begin
            wait_bits(5);
            @(posedge clk); #1 bus.dac_stp_ext = 1'b1;
            @(posedge clk); #1 bus.dac_stp_ext = 1'b0;
            m_over = 1'b1;
        end
        t = 0;
        while (done_cyc_q.size() == n0 && t < 400) begin @(negedge clk); t++; end
        if (done_cyc_q.size() == n0) begin
            check("frame_done_timeout", done_cyc_q.size(), n0 + 1);
        end else begin
            check("frame_word", word_q[n0], exp_word);
            check("frame_bits", bits_q[n0], DW);
            check("frame_done_cycle", done_cyc_q[n0], sc + FRAME_LAT);
            check("first_rise_cycle", first_rise, sc + 1 + HD);
            check("underrun", {31'd0, bus.underrun}, {31'd0, m_under});
            check("overrun", {31'd0, bus.overrun}, {31'd0, m_over});
            repeat (GC + 5) @(negedge clk);
            check("single_frame_done", done_cyc_q.size(), n0 + 1);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        logic [DW-1:0] exp_word;
        bit            mid_start;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, sc, t;
        bus.slp = 1'b0; bus.rst_adc = 1'b0; bus.dac_stp_ext = 1'b0;
        bus.sample_data = '0; bus.sample_valid = 1'b0;

        tbl[0] = '{16'hA5C3, 1'b1, 16'hA5C3, 1'b0};
        tbl[1] = '{16'hBEEF, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{16'hA5C3, 1'b1, 16'hA5C3, 1'b0};
        tbl[3] = '{16'hA5C3, 1'b1, 16'hA5C3, 1'b1};
        tbl[4] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_clk_s_d_out", {31'd0, bus.clk_s_d_out}, 32'd0);
        check("rst_adc_out",     {31'd0, bus.adc_out},     32'd0);
        check("rst_busy",        {31'd0, bus.busy},        32'd0);
        check("rst_frame_done",  {31'd0, bus.frame_done},  32'd0);
        check("rst_underrun",    {31'd0, bus.underrun},    32'd0);
        check("rst_overrun",     {31'd0, bus.overrun},     32'd0);
        @(posedge clk); #1 rst = 1'b0;

`ifdef ADC_TX_PATTERN_EN
        for (int i = 0; i < 3; i++) begin
            run_frame(DW'($urandom), 1'($urandom), m_ramp, 1'b0);
            m_ramp = m_ramp + 1'b1;
        end
`else
        for (int i = 0; i < 5; i++)
            run_frame(tbl[i].data, tbl[i].valid, tbl[i].exp_word, tbl[i].mid_start);

        for (int i = 0; i < 6; i++) begin
            logic [DW-1:0] d;
            logic          v;
            d = DW'($urandom);
            v = ($urandom_range(0, 3) != 0);
            run_frame(d, v, v ? d : '0, 1'b0);
        end

        // sleep mid-frame aborts without frame_done
        wait_idle();
        @(posedge clk); #1;
        bus.sample_data = 16'hA5C3; bus.sample_valid = 1'b1; bus.dac_stp_ext = 1'b1;
        n0 = done_cyc_q.size();
        @(posedge clk); #1 bus.dac_stp_ext = 1'b0;
        wait_bits(5);
        @(posedge clk); #1 bus.slp = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_clk_s_d_out", {31'd0, bus.clk_s_d_out}, 32'd0);
        check("abort_adc_out",     {31'd0, bus.adc_out},     32'd0);
        check("abort_busy",        {31'd0, bus.busy},        32'd0);
        @(posedge clk); #1 bus.dac_stp_ext = 1'b1;
        @(negedge clk);
        check("abort_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        @(posedge clk); #1 bus.dac_stp_ext = 1'b0;
        repeat (200) @(negedge clk);
        check("abort_no_frame_done", done_cyc_q.size(), n0);
        check("abort_busy_late", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1 bus.slp = 1'b0;
        run_frame(16'h1234, 1'b1, 16'h1234, 1'b0);

        // held-high start gives exactly one frame
        wait_idle();
        @(posedge clk); #1;
        bus.sample_data = 16'h5A5A; bus.sample_valid = 1'b1; bus.dac_stp_ext = 1'b1;
        sc = cyc;
        n0 = done_cyc_q.size();
        repeat (500) @(negedge clk);
        @(posedge clk); #1 bus.dac_stp_ext = 1'b0;
        repeat (20) @(negedge clk);
        check("held_frame_count", done_cyc_q.size(), n0 + 1);
        if (done_cyc_q.size() > n0) begin
            check("held_frame_word", word_q[n0], 16'h5A5A);
            check("held_frame_cycle", done_cyc_q[n0], sc + FRAME_LAT);
        end

        // rst_adc during start: no frame, no flags (after clearing the stickies)
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_under = 1'b0; m_over = 1'b0;
        @(posedge clk); #1 bus.rst_adc = 1'b1; bus.sample_valid = 1'b0;
        @(posedge clk); #1 bus.dac_stp_ext = 1'b1;
        n0 = done_cyc_q.size();
        @(negedge clk);
        check("rst_adc_sample_ready", {31'd0, bus.sample_ready}, 32'd0);
        t = 0;
        while (t < 200) begin @(negedge clk); t++; end
        check("rst_adc_no_frame", done_cyc_q.size(), n0);
        check("rst_adc_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_adc_underrun", {31'd0, bus.underrun}, 32'd0);
        check("rst_adc_overrun", {31'd0, bus.overrun}, 32'd0);
        @(posedge clk); #1 bus.dac_stp_ext = 1'b0;
        @(posedge clk); #1 bus.rst_adc = 1'b0;
        run_frame(16'hC001, 1'b1, 16'hC001, 1'b0);
`endif

        check("adc_out_stability", stab_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
